// File: rtl/execute_muldiv_pkg.sv
// Shared definitions for the execute-stage RV64M multiply/divide sequencer:
// funct3 encodings, FSM states, the signed-overflow dividend and op decode.
package execute_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [63:0] MD_OVF_CONST = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic is_div;
        logic is_signed_a;
        logic is_signed_b;
    } md_decode_t;

    function automatic md_decode_t md_decode(input logic [2:0] op);
        md_decode_t d;
        d.is_div      = op[2];
        d.is_signed_a = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU)
                     || (op == OP_DIV) || (op == OP_REM);
        d.is_signed_b = (op == OP_MUL) || (op == OP_MULH)
                     || (op == OP_DIV) || (op == OP_REM);
        return d;
    endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Iterative shift-add multiplier / restoring divider datapath working on
// operand magnitudes; sign correction is applied once when the op finishes.
module muldiv_iter_datapath
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_finish,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    output logic            o_fast,
    output logic [XLEN-1:0] o_result
);

    localparam logic [XLEN-1:0] W_OVF = XLEN'(MD_OVF_CONST >> (64 - XLEN));

    md_decode_t        w_dec;
    logic              w_signA, w_signB, w_divZero, w_overflow, w_isRemReq;
    logic [XLEN-1:0]   w_absA, w_absB, w_fastResult;
    logic [2:0]        r_op;
    logic              r_isDiv, r_signA, r_signB;
    logic [XLEN-1:0]   r_operand, r_result;
    logic [2*XLEN-1:0] r_acc, w_accNext, w_product;
    logic [XLEN:0]     w_sum, w_remShift, w_diff;
    logic [XLEN-1:0]   w_quotient, w_remainder, w_iterResult;

    assign w_dec      = md_decode(i_op);
    assign w_signA    = w_dec.is_signed_a & i_srcA[XLEN-1];
    assign w_signB    = w_dec.is_signed_b & i_srcB[XLEN-1];
    assign w_absA     = w_signA ? -i_srcA : i_srcA;
    assign w_absB     = w_signB ? -i_srcB : i_srcB;
    assign w_divZero  = (i_srcB == '0);
    assign w_overflow = w_dec.is_signed_a & (i_srcA == W_OVF) & (i_srcB == '1);
    assign w_isRemReq = (i_op == OP_REM) || (i_op == OP_REMU);
    assign o_fast     = w_dec.is_div & (w_divZero | w_overflow);
    assign w_fastResult = w_divZero ? (w_isRemReq ? i_srcA : '1)
                                    : (w_isRemReq ? '0 : W_OVF);

    // Multiply keeps the multiplier in the low half and the multiplicand in
    // r_operand; divide keeps the quotient low and the partial remainder high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_isDiv   <= 1'b0;
            r_signA   <= 1'b0;
            r_signB   <= 1'b0;
            r_operand <= '0;
            r_acc     <= '0;
        end else if (i_load) begin
            r_op      <= i_op;
            r_isDiv   <= w_dec.is_div;
            r_signA   <= w_signA;
            r_signB   <= w_signB;
            r_operand <= w_dec.is_div ? w_absB : w_absA;
            r_acc     <= {{XLEN{1'b0}}, (w_dec.is_div ? w_absA : w_absB)};
        end else if (i_step) begin
            r_acc     <= w_accNext;
        end
    end

    always_comb begin
        w_accNext  = r_acc;
        w_sum      = '0;
        w_remShift = '0;
        w_diff     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_isDiv) begin
                w_remShift = {w_accNext[2*XLEN-1:XLEN], w_accNext[XLEN-1]};
                w_diff     = w_remShift - {1'b0, r_operand};
                if (!w_diff[XLEN])
                    w_accNext = {w_diff[XLEN-1:0], w_accNext[XLEN-2:0], 1'b1};
                else
                    w_accNext = {w_remShift[XLEN-1:0], w_accNext[XLEN-2:0], 1'b0};
            end else begin
                w_sum     = {1'b0, w_accNext[2*XLEN-1:XLEN]}
                          + (w_accNext[0] ? {1'b0, r_operand} : {(XLEN+1){1'b0}});
                w_accNext = {w_sum, w_accNext[XLEN-1:1]};
            end
        end
    end

    assign w_product   = (r_signA ^ r_signB) ? -w_accNext : w_accNext;
    assign w_quotient  = (r_signA ^ r_signB) ? -w_accNext[XLEN-1:0] : w_accNext[XLEN-1:0];
    assign w_remainder = r_signA ? -w_accNext[2*XLEN-1:XLEN] : w_accNext[2*XLEN-1:XLEN];

    always_comb begin
        w_iterResult = w_remainder;
        case (r_op)
            OP_MUL:                        w_iterResult = w_product[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_iterResult = w_product[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_iterResult = w_quotient;
            default:                       w_iterResult = w_remainder;
        endcase
    end

    // Finishing from IDLE is the divide-by-zero/overflow shortcut.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_result <= '0;
        else if (i_finish)
            r_result <= i_load ? w_fastResult : w_iterResult;
    end

    assign o_result = r_result;

endmodule

// File: rtl/execute_muldiv_ctrl.sv
// Execute-stage M-extension sequencer: stalls the pipeline while the
// iterative datapath runs and presents a one-cycle done pulse with the result.
module execute_muldiv_ctrl
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            KillE,
    output logic            StallMD,
    output logic            MulDivDoneE,
    output logic [XLEN-1:0] MulDivResultE,
    output logic            BusyE
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t           r_state, w_nextState;
    logic [CNT_W-1:0] r_count;
    logic             w_load, w_step, w_finish, w_fast;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (w_load)
            r_count <= '0;
        else if (w_step)
            r_count <= r_count + 1'b1;
    end

    // A kill drops the stall in the same cycle so the redirect is not held off.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        StallMD     = 1'b0;
        MulDivDoneE = 1'b0;
        BusyE       = 1'b0;
        case (r_state)
            IDLE: begin
                if (MulDivE && !KillE) begin
                    StallMD = 1'b1;
                    w_load  = 1'b1;
                    if (w_fast) begin
                        w_finish    = 1'b1;
                        w_nextState = DONE;
                    end else begin
                        w_nextState = RUN;
                    end
                end
            end
            RUN: begin
                BusyE = 1'b1;
                if (KillE) begin
                    w_nextState = IDLE;
                end else begin
                    StallMD = 1'b1;
                    w_step  = 1'b1;
                    if (r_count == CNT_W'(N - 1)) begin
                        w_finish    = 1'b1;
                        w_nextState = DONE;
                    end
                end
            end
            DONE: begin
                MulDivDoneE = ~KillE;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    muldiv_iter_datapath #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_finish (w_finish),
        .i_op     (MulDivOpE),
        .i_srcA   (SrcAE),
        .i_srcB   (SrcBE),
        .o_fast   (w_fast),
        .o_result (MulDivResultE)
    );

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Scoreboard bench for execute_muldiv_ctrl: expected results are queued at
// issue and popped when the done pulse appears; latency and stall are checked.
module tb_execute_muldiv_ctrl;
    import execute_muldiv_pkg::*;

    localparam logic [63:0] OVF  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        MulDivE = 1'b0;
    logic [2:0]  MulDivOpE = 3'd0;
    logic [63:0] SrcAE = '0;
    logic [63:0] SrcBE = '0;
    logic        KillE = 1'b0;
    logic        StallMD, MulDivDoneE, BusyE;
    logic [63:0] MulDivResultE;

    int errorCount = 0;
    int checkCount = 0;
    logic [63:0] expQueue [$];

    execute_muldiv_ctrl #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .MulDivE       (MulDivE),
        .MulDivOpE     (MulDivOpE),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .KillE         (KillE),
        .StallMD       (StallMD),
        .MulDivDoneE   (MulDivDoneE),
        .MulDivResultE (MulDivResultE),
        .BusyE         (BusyE)
    );

    always #5 clock = ~clock;

    // Plain arithmetic reference with RISC-V divide corner cases.
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ub;
        logic        [127:0] prod;
        logic signed [63:0]  qa, qb;
        logic        [63:0]  r;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ub = {64'b0, b};
        qa = a;
        qb = b;
        r  = '0;
        case (op)
            OP_MUL:    begin prod = sa * sb; r = prod[63:0];   end
            OP_MULH:   begin prod = sa * sb; r = prod[127:64]; end
            OP_MULHSU: begin prod = sa * ub; r = prod[127:64]; end
            OP_MULHU:  begin prod = {64'b0, a} * {64'b0, b}; r = prod[127:64]; end
            OP_DIV:    r = (b == 0) ? ONES : ((a == OVF && b == ONES) ? OVF : 64'(qa / qb));
            OP_DIVU:   r = (b == 0) ? ONES : a / b;
            OP_REM:    r = (b == 0) ? a : ((a == OVF && b == ONES) ? 64'd0 : 64'(qa % qb));
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(posedge clock); #1;
        MulDivE   = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
    endtask

    task automatic releaseReq();
        @(posedge clock); #1;
        MulDivE = 1'b0;
    endtask

    // Counts cycles from the issue cycle (cycle 1) up to the done pulse.
    task automatic waitDone(output bit done, output int cycles, output int stalls, output logic [63:0] res);
        done = 1'b0; cycles = 0; stalls = 0; res = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            cycles++;
            if (StallMD === 1'b1) stalls++;
            if (MulDivDoneE === 1'b1) begin
                done = 1'b1;
                res  = MulDivResultE;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checkCount++; if (StallMD !== 1'b0)       begin errorCount++; $display("[TB] FAIL reset_stall: got %b want 0", StallMD); end
        checkCount++; if (MulDivDoneE !== 1'b0)   begin errorCount++; $display("[TB] FAIL reset_done: got %b want 0", MulDivDoneE); end
        checkCount++; if (BusyE !== 1'b0)         begin errorCount++; $display("[TB] FAIL reset_busy: got %b want 0", BusyE); end
        checkCount++; if (MulDivResultE !== 64'd0) begin errorCount++; $display("[TB] FAIL reset_result: got %h want 0", MulDivResultE); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic test_multiply();
        logic [2:0]  opTab [3];
        logic [63:0] aTab [3], bTab [3], eTab [3];
        logic [63:0] res, expected;
        bit done; int cycles, stalls;
        opTab = '{OP_MUL, OP_MULHU, OP_MULH};
        aTab  = '{64'd7, ONES, ONES};
        bTab  = '{-64'sd3, ONES, ONES};
        eTab  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(opTab[i], aTab[i], bTab[i]);
            expQueue.push_back(eTab[i]);
            waitDone(done, cycles, stalls, res);
            expected = expQueue.pop_front();
            checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL mul%0d_result: got %h (done=%0d) want %h", i, res, done, expected); end
            checkCount++; if (cycles !== 66) begin errorCount++; $display("[TB] FAIL mul%0d_latency: got %0d want 66", i, cycles); end
            checkCount++; if (stalls !== 65) begin errorCount++; $display("[TB] FAIL mul%0d_stall: got %0d want 65", i, stalls); end
        end
        releaseReq();
    endtask

    task automatic test_divide();
        logic [2:0]  opTab [6];
        logic [63:0] aTab [6], bTab [6], eTab [6];
        logic [63:0] res, expected;
        bit done; int cycles, stalls;
        opTab = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_DIV};
        aTab  = '{64'd100, 64'd100, -64'sd100, -64'sd100, OVF, 64'd7};
        bTab  = '{64'd7, 64'd7, 64'd7, 64'd7, ONES, -64'sd100};
        eTab  = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(opTab[i], aTab[i], bTab[i]);
            expQueue.push_back(eTab[i]);
            waitDone(done, cycles, stalls, res);
            expected = expQueue.pop_front();
            checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL div%0d_result: got %h (done=%0d) want %h", i, res, done, expected); end
            checkCount++; if (cycles !== 66) begin errorCount++; $display("[TB] FAIL div%0d_latency: got %0d want 66", i, cycles); end
            checkCount++; if (stalls !== 65) begin errorCount++; $display("[TB] FAIL div%0d_stall: got %0d want 65", i, stalls); end
        end
        releaseReq();
    endtask

    task automatic test_fast_path();
        logic [2:0]  opTab [6];
        logic [63:0] aTab [6], bTab [6], eTab [6];
        logic [63:0] res, expected;
        bit done; int cycles, stalls;
        opTab = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        aTab  = '{64'd5, 64'd5, OVF, OVF, 64'd5, 64'd5};
        bTab  = '{64'd0, 64'd0, ONES, ONES, 64'd0, 64'd0};
        eTab  = '{ONES, 64'd5, OVF, 64'd0, ONES, 64'd5};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(opTab[i], aTab[i], bTab[i]);
            expQueue.push_back(eTab[i]);
            waitDone(done, cycles, stalls, res);
            expected = expQueue.pop_front();
            checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL fast%0d_result: got %h (done=%0d) want %h", i, res, done, expected); end
            checkCount++; if (cycles !== 2) begin errorCount++; $display("[TB] FAIL fast%0d_latency: got %0d want 2", i, cycles); end
            checkCount++; if (stalls !== 1) begin errorCount++; $display("[TB] FAIL fast%0d_stall: got %0d want 1", i, stalls); end
        end
        releaseReq();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  opTab [3];
        logic [63:0] aTab [3], bTab [3], eTab [3];
        int          latTab [3];
        logic [63:0] res, expected;
        bit done; int cycles, stalls;
        opTab  = '{OP_DIV, OP_MUL, OP_REMU};
        aTab   = '{64'd5, 64'd3, 64'd100};
        bTab   = '{64'd0, 64'd5, 64'd7};
        eTab   = '{ONES, 64'd15, 64'd2};
        latTab = '{2, 66, 66};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(opTab[i], aTab[i], bTab[i]);
            expQueue.push_back(eTab[i]);
            waitDone(done, cycles, stalls, res);
            expected = expQueue.pop_front();
            checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL b2b%0d_result: got %h (done=%0d) want %h", i, res, done, expected); end
            checkCount++; if (cycles !== latTab[i]) begin errorCount++; $display("[TB] FAIL b2b%0d_latency: got %0d want %0d", i, cycles, latTab[i]); end
        end
        releaseReq();
    endtask

    task automatic test_kill();
        logic [63:0] res, expected;
        bit done; int cycles, stalls, doneSeen;
        applyStimulus(OP_MUL, 64'd123, 64'd456);
        repeat (10) @(posedge clock);
        #1 KillE = 1'b1;
        #1;
        checkCount++; if (StallMD !== 1'b0)     begin errorCount++; $display("[TB] FAIL kill_stall: got %b want 0", StallMD); end
        checkCount++; if (MulDivDoneE !== 1'b0) begin errorCount++; $display("[TB] FAIL kill_done: got %b want 0", MulDivDoneE); end
        @(posedge clock); #2;
        checkCount++; if (BusyE !== 1'b0)   begin errorCount++; $display("[TB] FAIL kill_idle_busy: got %b want 0", BusyE); end
        checkCount++; if (StallMD !== 1'b0) begin errorCount++; $display("[TB] FAIL kill_idle_stall: got %b want 0", StallMD); end
        @(posedge clock); #2;
        checkCount++; if (BusyE !== 1'b0) begin errorCount++; $display("[TB] FAIL kill_blocks_start: got busy %b want 0", BusyE); end
        KillE   = 1'b0;
        MulDivE = 1'b0;
        doneSeen = 0;
        repeat (80) begin
            @(negedge clock);
            if (MulDivDoneE === 1'b1) doneSeen++;
        end
        checkCount++; if (doneSeen !== 0) begin errorCount++; $display("[TB] FAIL kill_no_done: got %0d pulses want 0", doneSeen); end
        applyStimulus(OP_DIVU, 64'd9, 64'd3);
        expQueue.push_back(64'd3);
        waitDone(done, cycles, stalls, res);
        expected = expQueue.pop_front();
        checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL kill_after_result: got %h (done=%0d) want %h", res, done, expected); end
        checkCount++; if (cycles !== 66) begin errorCount++; $display("[TB] FAIL kill_after_latency: got %0d want 66", cycles); end
        releaseReq();
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] res, expected;
        bit done; int cycles, stalls;
        applyStimulus(OP_MUL, 64'd123, 64'd456);
        repeat (30) @(posedge clock);
        #3;
        reset   = 1'b0;
        MulDivE = 1'b0;
        #1;
        checkCount++; if (BusyE !== 1'b0)          begin errorCount++; $display("[TB] FAIL rst_run_busy: got %b want 0", BusyE); end
        checkCount++; if (StallMD !== 1'b0)        begin errorCount++; $display("[TB] FAIL rst_run_stall: got %b want 0", StallMD); end
        checkCount++; if (MulDivDoneE !== 1'b0)    begin errorCount++; $display("[TB] FAIL rst_run_done: got %b want 0", MulDivDoneE); end
        checkCount++; if (MulDivResultE !== 64'd0) begin errorCount++; $display("[TB] FAIL rst_run_result: got %h want 0", MulDivResultE); end
        @(posedge clock);
        @(negedge clock) reset = 1'b1;
        applyStimulus(OP_MUL, 64'd6, 64'd7);
        expQueue.push_back(64'd42);
        waitDone(done, cycles, stalls, res);
        expected = expQueue.pop_front();
        checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL rst_after_result: got %h (done=%0d) want %h", res, done, expected); end
        checkCount++; if (cycles !== 66) begin errorCount++; $display("[TB] FAIL rst_after_latency: got %0d want 66", cycles); end
        releaseReq();
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [63:0] a, b, res, expected;
        bit done, fast; int cycles, stalls;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = (i == 3) ? 64'd0 : {$urandom, $urandom};
            fast = op[2] && (b == 0 || (!op[0] && a == OVF && b == ONES));
            applyStimulus(op, a, b);
            expQueue.push_back(refModel(op, a, b));
            waitDone(done, cycles, stalls, res);
            expected = expQueue.pop_front();
            checkCount++; if (!done || res !== expected) begin errorCount++; $display("[TB] FAIL rand%0d_op%0d_result: got %h (done=%0d) want %h", i, op, res, done, expected); end
            checkCount++; if (cycles !== (fast ? 2 : 66)) begin errorCount++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", i, cycles, fast ? 2 : 66); end
        end
        releaseReq();
    endtask

    task automatic checkOutput();
        checkCount++;
        if (expQueue.size() !== 0) begin errorCount++; $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", expQueue.size()); end
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_fast_path();
        test_back_to_back();
        test_kill();
        test_reset_mid_run();
        test_random();
        checkOutput();
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/execute_muldiv_ctrl.md
Name: execute_muldiv_ctrl

Overview:
- Sequences a multi-cycle RV64M multiply/divide unit that sits beside the ALU in the execute stage.
- Accepts the forwarded operands (post-forward SrcA / WriteData values) when a M-extension instruction is in execute.
- Iterates a shift-add multiplier or restoring divider, and holds the pipeline via a stall request to the hazard unit until the result is ready.
- Delivers a one-cycle result that the execute result mux selects in place of ALUResultE.

Parameters:
- XLEN, 64, operand/result width.
- BITS_PER_CYCLE, 1, iteration bits per clock; legal values 1, 2, 4. Iteration count N = XLEN/BITS_PER_CYCLE.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- MulDivE  in  1  M-extension instruction valid in execute; held high while stalled.
- MulDivOpE  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcAE  in  XLEN  forwarded rs1 value.
- SrcBE  in  XLEN  forwarded rs2 value.
- KillE  in  1  abort the in-flight op (trap/redirect).
- StallMD  out  1  stall F/D/E and bubble M.
- MulDivDoneE  out  1  result valid this cycle.
- MulDivResultE  out  XLEN  result.
- BusyE  out  1  iteration in progress.

Behaviour:
- States are IDLE, RUN, DONE. Async reset (reset=0) forces IDLE, counter 0, MulDivDoneE=0, MulDivResultE=0, BusyE=0, StallMD=0.
- StallMD = (IDLE & MulDivE & ~KillE) | RUN. It is combinational and deasserts in DONE so the pipeline advances while the result is on the bus.
- IDLE, when MulDivE=1 and KillE=0 at edge t:
  - latch |SrcA| and |SrcB| per signedness, the result-sign flags and the op.
  - fast path: divide by zero, or signed overflow (DIV/REM with SrcA = 0x8000_0000_0000_0000 and SrcB = -1), goes to DONE at t+1.
  - otherwise go to RUN, counter=0.
- RUN: each cycle retires BITS_PER_CYCLE bits.
  - multiply: shift-add into a 2*XLEN accumulator.
  - divide: restoring subtract with quotient shift-in.
  - after N cycles go to DONE, so a normal op is in DONE at t+N+1 (66 cycles for the defaults).
- DONE: MulDivDoneE=1 for exactly one cycle. MulDivResultE is sign-corrected and held until the next DONE. Next state is IDLE unconditionally; the still-high MulDivE in DONE is not a new request.
- Result selection:
  - MUL gives the low XLEN bits.
  - MULH, MULHSU and MULHU give the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - Quotient sign = signA^signB; remainder sign = signA.
- Divide by zero: quotient = all ones; remainder = SrcA.
- Overflow: quotient = 0x8000_0000_0000_0000; remainder = 0.
- KillE in RUN or DONE forces IDLE next edge. MulDivDoneE is suppressed in that cycle, and StallMD drops in the same cycle combinationally.
- KillE in IDLE blocks the start.
- Back-to-back ops: a new MulDivE seen in IDLE the cycle after DONE starts normally. There is no idle gap beyond the single IDLE cycle.
- Reset mid-RUN: immediate IDLE; the partial result is discarded.

Decomposition:
- Package execute_muldiv_pkg holds:
  - the funct3 op localparams.
  - the state enum (IDLE/RUN/DONE).
  - the overflow constant.
  - an is_div / is_signed_a / is_signed_b decode function.
- One sub-module, muldiv_iter_datapath, holds the accumulator/quotient/remainder registers and the per-cycle step logic. It is controlled by load/step/finish strobes from the FSM.

Test Plan:
- MUL, SrcA=7, SrcB=-3: StallMD high for 65 cycles, then MulDivDoneE at cycle 66 with result 0xFFFF_FFFF_FFFF_FFEB.
- MULHU, SrcA=SrcB=0xFFFF_FFFF_FFFF_FFFF: result 0xFFFF_FFFF_FFFF_FFFE. MULH, SrcA=-1, SrcB=-1: result 0.
- DIVU 100/7 gives 14; REMU gives 2. DIV -100/7 gives -14 (0xFFFF_FFFF_FFFF_FFF2); REM gives -2.
- Fast path:
  - DIV 5/0 gives 0xFFFF_FFFF_FFFF_FFFF, done at cycle 2.
  - REM 5/0 gives 5.
  - DIV 0x8000_0000_0000_0000/-1 gives 0x8000_0000_0000_0000; REM gives 0.
  - StallMD is high for exactly one cycle in each case.
- KillE pulsed at RUN cycle 10: StallMD low that cycle, state IDLE next edge, no MulDivDoneE. A following DIVU 9/3 then returns 3.
- reset pulled low at RUN cycle 30: all outputs 0 asynchronously. After release, MUL 6*7 returns 42 with full latency.
